// File: rtl/instr_stream_packer_pkg.sv
// Shared definitions for the instruction-stream writer and the fetch-side reader.
// The word width and immediate flag position must match on both ends of the image.
package instr_stream_packer_pkg;

  localparam int WORD_W       = 16;
  localparam int IMM_FLAG_BIT = 2;

  typedef enum logic {
    S_INSTR = 1'b0,
    S_IMM   = 1'b1
  } pack_state_t;

  // True when this instruction word is followed by a 16-bit immediate word.
  function automatic logic instr_has_imm(input logic [WORD_W-1:0] instr, input int flag_bit);
    return instr[flag_bit];
  endfunction

endpackage

// File: rtl/instr_stream_packer.sv
// Packs instructions, plus an optional trailing immediate, into consecutive
// instruction-memory words, one word per cycle, with all write outputs registered.
module instr_stream_packer
  import instr_stream_packer_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int IMM_BIT = IMM_FLAG_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_instr,
  input  logic [WORD_W-1:0] in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
  output logic              mem_is_imm,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  // One extra pointer bit so "one past the last word" is representable.
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  pack_state_t       state_reg, state_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [WORD_W-1:0] imm_reg, imm_next;
  logic              full_reg, full_next;
  logic              err_reg, err_next;
  logic              ready_reg, ready_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [WORD_W-1:0] data_reg, data_next;
  logic              is_imm_reg, is_imm_next;

  logic              accept;
  logic              want_imm;
  logic [PTR_W-1:0]  ptr_plus1;
  logic              room_for_two;

  assign in_ready     = ready_reg & ~addr_load;
  assign accept       = in_valid & in_ready;
  assign want_imm     = instr_has_imm(in_instr, IMM_BIT);
  assign ptr_plus1    = ptr_reg + PTR_W'(1);
  assign room_for_two = (ptr_reg + PTR_W'(2)) <= DEPTH_P;

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    imm_next    = imm_reg;
    full_next   = full_reg;
    err_next    = err_reg;
    cnt_next    = cnt_reg;
    we_next     = 1'b0;
    addr_next   = addr_reg;
    data_next   = data_reg;
    is_imm_next = is_imm_reg;

    if (addr_load) begin
      // Reload discards any immediate still waiting to be written.
      state_next = S_INSTR;
      ptr_next   = {1'b0, base_addr};
      full_next  = {1'b0, base_addr} >= DEPTH_P;
      err_next   = 1'b0;
      cnt_next   = '0;
    end else if (state_reg == S_IMM) begin
      we_next     = 1'b1;
      addr_next   = ptr_reg[ADDR_W-1:0];
      data_next   = imm_reg;
      is_imm_next = 1'b1;
      ptr_next    = ptr_plus1;
      full_next   = ptr_plus1 >= DEPTH_P;
      cnt_next    = cnt_reg + 1'b1;
      state_next  = S_INSTR;
    end else if (accept) begin
      if (want_imm && !room_for_two) begin
        err_next = 1'b1;
      end else begin
        we_next     = 1'b1;
        addr_next   = ptr_reg[ADDR_W-1:0];
        data_next   = in_instr;
        is_imm_next = 1'b0;
        ptr_next    = ptr_plus1;
        full_next   = ptr_plus1 >= DEPTH_P;
        cnt_next    = cnt_reg + 1'b1;
        if (want_imm) begin
          imm_next   = in_imm;
          state_next = S_IMM;
        end
      end
    end

    ready_next = (state_next == S_INSTR) & ~full_next & ~err_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_INSTR;
      ptr_reg    <= '0;
      imm_reg    <= '0;
      full_reg   <= 1'b0;
      err_reg    <= 1'b0;
      ready_reg  <= 1'b0;
      cnt_reg    <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      data_reg   <= '0;
      is_imm_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      imm_reg    <= imm_next;
      full_reg   <= full_next;
      err_reg    <= err_next;
      ready_reg  <= ready_next;
      cnt_reg    <= cnt_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      is_imm_reg <= is_imm_next;
    end
  end

  assign mem_we     = we_reg;
  assign mem_addr   = addr_reg;
  assign mem_data   = data_reg;
  assign mem_is_imm = is_imm_reg;
  assign full       = full_reg;
  assign err        = err_reg;
  assign word_cnt   = cnt_reg;

endmodule
